keypad_scan_ctrl: RTL and testbench

Sequencer for the 4x4 matrix keypad. Drives the active-low row lines in rotation and senses the active-low column lines through a synchronizer. Freezes on a press, debounces press and release, and emits exactly one `key_valid` pulse per physical keypress with the decoded key. Sits between the keypad pins and the display/entry logic, replacing free-running row scanning.

---
 rtl/keypad_scan_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// ----------------
// Scan sequencer for a 4x4 active-low matrix keypad. Rotates a single low
// row drive, watches the synchronized column lines, freezes the scan when a
// single key is seen, debounces both press and release, and reports exactly
// one key_valid pulse per physical keypress together with the decoded key.
//
// Parameters
//   SCAN_DIV        : cycles spent on each row while scanning (>= 4)
//   DEBOUNCE_CYCLES : stable cycles needed to accept a press or a release (>= 2)
//
// Ports
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   cols      : raw column lines, active-low, asynchronous to clk
//   rows      : row drive, active-low, at most one bit low
//   key_val   : {row_onehot, col_onehot} of the last accepted key
//   key_hex   : hex code of the last accepted key
//   key_valid : one-cycle pulse when a press is accepted
//   key_held  : high from press acceptance until release acceptance

module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [7:0] key_val,
    output logic [3:0] key_hex,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_BLANK = DW'(3);
    localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } state_t;

    state_t        state, state_next;
    logic [3:0]    sync1, cs;
    logic [1:0]    row_idx, row_idx_next;
    logic [DW-1:0] dwell, dwell_next;
    logic [CW-1:0] db_cnt, db_cnt_next;
    logic [3:0]    cap_col, cap_col_next;
    logic [1:0]    cap_idx, cap_idx_next;
    logic [3:0]    rows_next;
    logic [7:0]    key_val_next;
    logic [3:0]    key_hex_next;
    logic          key_valid_next;
    logic          key_held_next;
    logic          cs_single;
    logic [1:0]    cs_idx;
    logic          cap_bit_high;

    // Key legend lookup, row-major over the physical keypad layout.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer for the asynchronous column lines. Idle level is
    // all-high so a reset never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 4'hF;
            cs    <= 4'hF;
        end else begin
            sync1 <= cols;
            cs    <= sync1;
        end
    end

    // A pattern only counts as a press when exactly one column is low;
    // idle and multi-key patterns are both treated as nothing pressed.
    always_comb begin
        cs_single = 1'b1;
        cs_idx    = 2'd0;
        case (cs)
            4'b1110: cs_idx = 2'd0;
            4'b1101: cs_idx = 2'd1;
            4'b1011: cs_idx = 2'd2;
            4'b0111: cs_idx = 2'd3;
            default: cs_single = 1'b0;
        endcase
    end

    // Once a key is held only its own column is of interest.
    assign cap_bit_high = cs[cap_idx];

    // Next-state and next-output logic. The first few dwell cycles after a
    // row change are ignored because cs still shows the previous row.
    always_comb begin
        state_next     = state;
        row_idx_next   = row_idx;
        dwell_next     = dwell;
        db_cnt_next    = db_cnt;
        cap_col_next   = cap_col;
        cap_idx_next   = cap_idx;
        key_val_next   = key_val;
        key_hex_next   = key_hex;
        key_valid_next = 1'b0;
        key_held_next  = key_held;

        case (state)
            SCAN: begin
                if (dwell >= DWELL_BLANK && cs_single) begin
                    cap_col_next = cs;
                    cap_idx_next = cs_idx;
                    db_cnt_next  = CW'(1);
                    state_next   = DB_PRESS;
                end else if (dwell == DWELL_LAST) begin
                    row_idx_next = row_idx + 2'd1;
                    dwell_next   = '0;
                end else begin
                    dwell_next = dwell + DW'(1);
                end
            end

            DB_PRESS: begin
                if (cs == cap_col) begin
                    if (db_cnt >= DB_LAST) begin
                        state_next     = HELD;
                        db_cnt_next    = '0;
                        key_valid_next = 1'b1;
                        key_held_next  = 1'b1;
                        key_val_next   = {4'b0001 << row_idx, 4'b0001 << cap_idx};
                        key_hex_next   = key_code(row_idx, cap_idx);
                    end else begin
                        db_cnt_next = db_cnt + CW'(1);
                    end
                end else begin
                    state_next  = SCAN;
                    dwell_next  = '0;
                    db_cnt_next = '0;
                end
            end

            HELD: begin
                if (cap_bit_high) begin
                    state_next  = DB_RELEASE;
                    db_cnt_next = CW'(1);
                end
            end

            DB_RELEASE: begin
                if (cap_bit_high) begin
                    if (db_cnt >= DB_LAST) begin
                        state_next    = SCAN;
                        key_held_next = 1'b0;
                        row_idx_next  = row_idx + 2'd1;
                        dwell_next    = '0;
                        db_cnt_next   = '0;
                    end else begin
                        db_cnt_next = db_cnt + CW'(1);
                    end
                end else begin
                    state_next  = HELD;
                    db_cnt_next = '0;
                end
            end

            default: state_next = SCAN;
        endcase

        rows_next = ~(4'b0001 << row_idx_next);
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            dwell     <= '0;
            db_cnt    <= '0;
            cap_col   <= 4'hF;
            cap_idx   <= 2'd0;
            rows      <= 4'b1110;
            key_val   <= 8'h00;
            key_hex   <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_next;
            row_idx   <= row_idx_next;
            dwell     <= dwell_next;
            db_cnt    <= db_cnt_next;
            cap_col   <= cap_col_next;
            cap_idx   <= cap_idx_next;
            rows      <= rows_next;
            key_val   <= key_val_next;
            key_hex   <= key_hex_next;
            key_valid <= key_valid_next;
            key_held  <= key_held_next;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
// -------------------
// Self-checking bench for keypad_scan_ctrl with a small scan divider and
// debounce length. A keypad model pulls a column low only while its key is
// pressed and its row is driven low. A behavioural model of the controller
// predicts every output on every cycle; directed scenarios add literal checks.

module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;

    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    localparam logic [3:0] SCAN_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Model modes, named by what the keypad is doing
    localparam int LOOKING   = 0;
    localparam int SETTLING  = 1;
    localparam int DOWN      = 2;
    localparam int LIFTING   = 3;

    logic       clk;
    logic       reset;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [7:0] key_val;
    logic [3:0] key_hex;
    logic       key_valid;
    logic       key_held;

    logic [15:0] press;

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;

    // Model state
    bit         model_live = 0;
    int         m_mode, m_row, m_dwell, m_cnt, m_col;
    logic [3:0] hist [2];
    logic [3:0] exp_rows;
    logic [7:0] exp_val;
    logic [3:0] exp_hex;
    logic       exp_valid, exp_held;

    keypad_scan_ctrl #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .key_val   (key_val),
        .key_hex   (key_hex),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its column to its row when that row is driven low
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !rows[r]) cols[c] = 1'b0;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int r, input int c, input logic down);
        press[r*4+c] = down;
    endtask

    task automatic waitPulse(input string name, input int bound);
        int start;
        bit seen;
        start = pulses;
        seen  = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            if (pulses != start) seen = 1;
        end
        if (!seen) timeoutFail(name);
    endtask

    task automatic waitRelease(input string name, input int bound);
        bit seen;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            if (key_held === 1'b0) seen = 1;
        end
        if (!seen) timeoutFail(name);
    endtask

    // Behavioural model: the keypad as seen through a two-sample delay, with
    // dwell, debounce and held-key rules applied in plain integer arithmetic.
    always @(posedge clk) begin
        logic [3:0] seen_cols;
        if (reset) begin
            model_live = 1;
            m_mode  = LOOKING;
            m_row   = 0;
            m_dwell = 0;
            m_cnt   = 0;
            m_col   = 0;
            hist[0] = 4'hF;
            hist[1] = 4'hF;
            exp_valid = 1'b0;
            exp_held  = 1'b0;
            exp_val   = 8'h00;
            exp_hex   = 4'h0;
        end else begin
            seen_cols = hist[1];
            exp_valid = 1'b0;
            case (m_mode)
                LOOKING: begin
                    if (m_dwell >= 3 && $countones(~seen_cols) == 1) begin
                        for (int c = 0; c < 4; c++) if (!seen_cols[c]) m_col = c;
                        m_cnt  = 1;
                        m_mode = SETTLING;
                    end else begin
                        m_dwell++;
                        if (m_dwell == SCAN_DIV) begin
                            m_row   = (m_row + 1) % 4;
                            m_dwell = 0;
                        end
                    end
                end
                SETTLING: begin
                    if ($countones(~seen_cols) == 1 && !seen_cols[m_col]) begin
                        m_cnt++;
                        if (m_cnt == DEBOUNCE_CYCLES) begin
                            m_mode    = DOWN;
                            exp_valid = 1'b1;
                            exp_held  = 1'b1;
                            exp_val   = {4'(1 << m_row), 4'(1 << m_col)};
                            exp_hex   = KEY_MAP[m_row*4 + m_col];
                        end
                    end else begin
                        m_mode  = LOOKING;
                        m_dwell = 0;
                    end
                end
                DOWN: begin
                    if (seen_cols[m_col]) begin
                        m_mode = LIFTING;
                        m_cnt  = 1;
                    end
                end
                default: begin
                    if (seen_cols[m_col]) begin
                        m_cnt++;
                        if (m_cnt == DEBOUNCE_CYCLES) begin
                            exp_held = 1'b0;
                            m_mode   = LOOKING;
                            m_row    = (m_row + 1) % 4;
                            m_dwell  = 0;
                        end
                    end else begin
                        m_mode = DOWN;
                    end
                end
            endcase
            hist[1] = hist[0];
            hist[0] = cols;
        end
        exp_rows = ~(4'b0001 << m_row);
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("cyc_rows", rows, exp_rows);
            checkOutput("cyc_key_valid", key_valid, exp_valid);
            checkOutput("cyc_key_held", key_held, exp_held);
            checkOutput("cyc_key_val", key_val, exp_val);
            checkOutput("cyc_key_hex", key_hex, exp_hex);
        end
    end

    // Pulse counter used by the directed scenarios
    always @(negedge clk) begin
        if (key_valid === 1'b1) pulses++;
    end

    initial begin
        int base;
        bit found;

        reset = 1'b1;
        press = 16'h0000;
        tick();
        tick();
        reset = 1'b0;

        // Reset values and idle scan rotation
        checkOutput("reset_key_val", key_val, 8'h00);
        checkOutput("reset_key_hex", key_hex, 4'h0);
        checkOutput("reset_key_held", key_held, 1'b0);
        for (int i = 0; i < 17; i++) begin
            checkOutput($sformatf("scan_rows_%0d", i), rows, SCAN_SEQ[(i / 4) % 4]);
            tick();
        end
        checkOutput("scan_no_pulse", pulses, 0);

        // Clean press of "5"
        base = pulses;
        applyStimulus(1, 1, 1'b1);
        waitPulse("press5_pulse", 60);
        checkOutput("press5_valid", key_valid, 1'b1);
        checkOutput("press5_val", key_val, 8'b0010_0010);
        checkOutput("press5_hex", key_hex, 4'h5);
        checkOutput("press5_held", key_held, 1'b1);
        checkOutput("press5_rows", rows, 4'b1101);
        repeat (15) tick();
        checkOutput("press5_one_pulse", pulses - base, 1);
        checkOutput("press5_frozen", rows, 4'b1101);
        applyStimulus(1, 1, 1'b0);
        waitRelease("release5", 40);
        checkOutput("release5_rows", rows, 4'b1011);
        checkOutput("release5_val_kept", key_val, 8'b0010_0010);

        // Bounce on "D": glitch high at debounce count 5, then stable retry
        base = pulses;
        applyStimulus(3, 3, 1'b1);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (m_mode == SETTLING && m_cnt == 5) found = 1;
        end
        if (!found) timeoutFail("bounceD_reach5");
        applyStimulus(3, 3, 1'b0);
        repeat (3) tick();
        checkOutput("bounceD_no_pulse", pulses - base, 0);
        applyStimulus(3, 3, 1'b1);
        waitPulse("bounceD_retry_pulse", 60);
        checkOutput("bounceD_val", key_val, 8'b1000_1000);
        checkOutput("bounceD_hex", key_hex, 4'hD);
        checkOutput("bounceD_rows", rows, 4'b0111);
        checkOutput("bounceD_one_pulse", pulses - base, 1);
        applyStimulus(3, 3, 1'b0);
        waitRelease("releaseD", 40);

        // Release bounce on "1"
        base = pulses;
        applyStimulus(0, 0, 1'b1);
        waitPulse("press1_pulse", 60);
        checkOutput("press1_hex", key_hex, 4'h1);
        repeat (5) tick();
        applyStimulus(0, 0, 1'b0);
        repeat (4) tick();
        applyStimulus(0, 0, 1'b1);
        repeat (30) tick();
        checkOutput("rel_bounce_one_pulse", pulses - base, 1);
        checkOutput("rel_bounce_held", key_held, 1'b1);
        applyStimulus(0, 0, 1'b0);
        waitRelease("release1", 40);

        // Same-row second key while "1" is held
        base = pulses;
        applyStimulus(0, 0, 1'b1);
        waitPulse("press1b_pulse", 60);
        applyStimulus(0, 1, 1'b1);
        repeat (20) tick();
        checkOutput("second_key_no_pulse", pulses - base, 1);
        checkOutput("second_key_held", key_held, 1'b1);
        checkOutput("second_key_rows", rows, 4'b1110);
        checkOutput("second_key_hex", key_hex, 4'h1);
        applyStimulus(0, 0, 1'b0);
        waitRelease("release1_only", 40);
        applyStimulus(0, 1, 1'b0);
        checkOutput("second_key_rows_after", rows, 4'b1101);
        repeat (8) tick();

        // Reset while "9" is held
        base = pulses;
        applyStimulus(2, 2, 1'b1);
        waitPulse("press9_pulse", 60);
        checkOutput("press9_hex", key_hex, 4'h9);
        repeat (3) tick();
        reset = 1'b1;
        applyStimulus(2, 2, 1'b0);
        tick();
        checkOutput("midhold_rows", rows, 4'b1110);
        checkOutput("midhold_key_val", key_val, 8'h00);
        checkOutput("midhold_key_hex", key_hex, 4'h0);
        checkOutput("midhold_key_held", key_held, 1'b0);
        checkOutput("midhold_key_valid", key_valid, 1'b0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        checkOutput("midhold_no_new_pulse", pulses - base, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
